// File: rtl/execute_add.sv
// execute_add: execute stage of the pipelined add datapath.
// Takes the decoded rs/rt operand values plus destination index, forms the
// 32-bit wrapped sum with signed-overflow and zero flags, and hands the result
// to writeback through a main output register backed by one skid register.
// in_ready is registered and depends only on skid occupancy, so there is no
// combinational path from out_ready back to decode.
// Optional build macro EXEC_OVF_TRAP_EN: overflowing results (dest != 0) are
// consumed but dropped, and a sticky ovf_trap flag is raised.
module execute_add #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_write_dest,
  input  logic [DATA_W-1:0] in_read_reg_1,
  input  logic [DATA_W-1:0] in_read_reg_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_write_dest,
  output logic [DATA_W-1:0] out_result,
  output logic              out_overflow,
  output logic              out_zero,
  output logic [31:0]       exec_count,
  output logic              ovf_trap
);

  // One buffered result as seen by writeback.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              zero;
  } entry_t;

  // Occupancy of the main/skid pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Add with signed-overflow detection; writes to register 0 are squashed to
  // a zero result with no overflow, but still travel down the pipe.
  function automatic entry_t compute_entry(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [ADDR_W-1:0] dest
  );
    entry_t             e;
    logic [DATA_W-1:0]  sum;
    logic               ovf;
    sum = a + b;
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    e.dest = dest;
    if (dest == {ADDR_W{1'b0}}) begin
      e.result = {DATA_W{1'b0}};
      e.ovf    = 1'b0;
    end else begin
      e.result = sum;
      e.ovf    = ovf;
    end
    e.zero = (e.result == {DATA_W{1'b0}});
    return e;
  endfunction

  // Reset image of a buffer entry: zero result, so the zero flag is set.
  localparam entry_t RESET_ENTRY = '{
    dest:   {ADDR_W{1'b0}},
    result: {DATA_W{1'b0}},
    ovf:    1'b0,
    zero:   1'b1
  };

  state_t        state_r;
  entry_t        main_r;
  entry_t        skid_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic [31:0]   count_r;

  entry_t        new_entry_s;
  logic          accept_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;

  assign new_entry_s = compute_entry(in_read_reg_1, in_read_reg_2, in_write_dest);
  assign accept_s    = in_valid & in_ready_r;
  assign push_s      = accept_s & ~drop_s;
  assign pop_s       = out_valid_r & out_ready;

`ifdef EXEC_OVF_TRAP_EN
  logic trap_r;

  // ovf is already cleared for dest==0, so only real overflowing writes drop.
  assign drop_s   = new_entry_s.ovf;
  assign ovf_trap = trap_r;

  // Sticky trap flag: set by any accepted overflowing instruction, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_r <= 1'b0;
    end else if (accept_s && drop_s) begin
      trap_r <= 1'b1;
    end else begin
      trap_r <= trap_r;
    end
  end
`else
  assign drop_s   = 1'b0;
  assign ovf_trap = 1'b0;
`endif

  // Main/skid occupancy FSM with registered out_valid and in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_ENTRY;
      skid_r      <= RESET_ENTRY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          in_ready_r <= 1'b1;
          if (push_s) begin
            main_r      <= new_entry_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_ONE;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_r     <= new_entry_s;
            in_ready_r <= 1'b1;
          end else if (push_s) begin
            skid_r     <= new_entry_s;
            state_r    <= ST_FULL;
            in_ready_r <= 1'b0;
          end else if (pop_s) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            main_r     <= skid_r;
            state_r    <= ST_ONE;
            in_ready_r <= 1'b1;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Accepted-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (accept_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign in_ready       = in_ready_r;
  assign out_valid      = out_valid_r;
  assign out_write_dest = main_r.dest;
  assign out_result     = main_r.result;
  assign out_overflow   = main_r.ovf;
  assign out_zero       = main_r.zero;
  assign exec_count     = count_r;

endmodule
